// File: rtl/fir_coeff_reload_seq_if.sv
// Settings-bus write port plus FIR reload/config AXI-stream channels, grouped for the coefficient loader.
// Latency: none, this file only bundles signals.
// Backpressure: reload_tready / config_tready are driven by the FIR side (master modport) into the loader.
interface fir_coeff_reload_seq_if #(
  parameter int COEFF_WIDTH = 16
);
  logic                   set_stb;
  logic [7:0]             set_addr;
  logic [31:0]            set_data;

  logic [COEFF_WIDTH-1:0] reload_tdata;
  logic                   reload_tvalid;
  logic                   reload_tlast;
  logic                   reload_tready;

  logic [7:0]             config_tdata;
  logic                   config_tvalid;
  logic                   config_tready;

  // Host / FIR side: issues settings writes and accepts the streams.
  modport master (
    output set_stb, set_addr, set_data, reload_tready, config_tready,
    input  reload_tdata, reload_tvalid, reload_tlast, config_tdata, config_tvalid
  );

  // Loader side: consumes settings writes and sources the streams.
  modport slave (
    input  set_stb, set_addr, set_data, reload_tready, config_tready,
    output reload_tdata, reload_tvalid, reload_tlast, config_tdata, config_tvalid
  );
endinterface

// File: rtl/fir_coeff_reload_seq.sv
// Buffers NUM_TAPS settings-bus coefficients, then streams them as one tlast packet plus a config beat.
// Latency: first reload beat the cycle after the commit strobe; NUM_TAPS beats, then config beat.
// Backpressure: beats advance only on tready; data/tlast held while stalled; writes while busy are dropped.
module fir_coeff_reload_seq #(
  parameter int         NUM_TAPS    = 129,
  parameter int         COEFF_WIDTH = 16,
  parameter logic [7:0] SR_COEFF    = 8'd128,
  parameter logic [7:0] SR_LOAD     = 8'd129,
  parameter logic [7:0] SR_CLEAR    = 8'd130,
  parameter int         CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  fir_coeff_reload_seq_if.slave bus,
  output logic                  busy,
  output logic [CNT_W-1:0]      coeff_count,
  output logic [15:0]           load_count,
  output logic [2:0]            err_flags
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_TAPS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RELOAD = 2'd1,
    ST_CONFIG = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       rd_idx, rd_idx_nxt;
  logic [COEFF_WIDTH-1:0] mem [NUM_TAPS];

  logic       wr_coeff, wr_load, wr_clear, wr_any;
  logic       buf_full, beat_last;
  logic       mem_we, cnt_inc, cnt_clr, err_clr, load_done;
  logic [2:0] err_set;
  logic       unused_set_bits;

  assign wr_coeff  = bus.set_stb && (bus.set_addr == SR_COEFF);
  assign wr_load   = bus.set_stb && (bus.set_addr == SR_LOAD);
  assign wr_clear  = bus.set_stb && (bus.set_addr == SR_CLEAR);
  assign wr_any    = wr_coeff || wr_load || wr_clear;
  assign buf_full  = (coeff_count == FULL_CNT);
  assign beat_last = (rd_idx == LAST_IDX);

  // Only the low COEFF_WIDTH bits of a settings word carry a coefficient.
  assign unused_set_bits = ^bus.set_data[31:COEFF_WIDTH];

  assign bus.reload_tvalid = (state == ST_RELOAD);
  assign bus.reload_tdata  = mem[rd_idx];
  assign bus.reload_tlast  = (state == ST_RELOAD) && beat_last;
  assign bus.config_tvalid = (state == ST_CONFIG);
  assign bus.config_tdata  = 8'h00;
  assign busy              = (state != ST_IDLE);

  // Next-state and control strobes: settings writes act only in IDLE; while busy they just flag an error.
  always_comb begin
    state_nxt  = state;
    rd_idx_nxt = rd_idx;
    mem_we     = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    err_set    = 3'b000;
    err_clr    = 1'b0;
    load_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_coeff) begin
          if (buf_full) begin
            err_set[0] = 1'b1;
          end else begin
            mem_we  = 1'b1;
            cnt_inc = 1'b1;
          end
        end else if (wr_load) begin
          if (buf_full) begin
            rd_idx_nxt = '0;
            state_nxt  = ST_RELOAD;
          end else begin
            err_set[1] = 1'b1;
          end
        end else if (wr_clear) begin
          cnt_clr = 1'b1;
          err_clr = 1'b1;
        end
      end
      ST_RELOAD: begin
        err_set[2] = wr_any;
        // tvalid is always high here, so tready alone completes a beat.
        if (bus.reload_tready) begin
          if (beat_last) begin
            state_nxt = ST_CONFIG;
          end else begin
            rd_idx_nxt = rd_idx + CNT_W'(1);
          end
        end
      end
      ST_CONFIG: begin
        err_set[2] = wr_any;
        if (bus.config_tready) begin
          cnt_clr   = 1'b1;
          load_done = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, read pointer, counters and sticky error flags; reset aborts any stream in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rd_idx      <= '0;
      coeff_count <= '0;
      load_count  <= 16'd0;
      err_flags   <= 3'b000;
    end else begin
      state  <= state_nxt;
      rd_idx <= rd_idx_nxt;
      if (cnt_clr) begin
        coeff_count <= '0;
      end else if (cnt_inc) begin
        coeff_count <= coeff_count + CNT_W'(1);
      end
      if (load_done) begin
        load_count <= load_count + 16'd1;
      end
      if (err_clr) begin
        err_flags <= 3'b000;
      end else begin
        err_flags <= err_flags | err_set;
      end
    end
  end

  // Coefficient buffer write; contents are not reset, the count alone says what is valid.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[coeff_count] <= bus.set_data[COEFF_WIDTH-1:0];
    end
  end

endmodule
